nanov_spi_ram: RTL and testbench

Single-clock SPI RAM responder that serves the nanoV CPU's instruction and data streams. It sits on the far side of the CPU's `spi_select` / `spi_out` / `spi_data_in` / `spi_clk_enable` lines and stands in for an external serial RAM in simulation and FPGA builds. It decodes read and write commands with a 24-bit address and streams bytes with address auto-increment. Both code and data are held in internal byte storage, with a backdoor port for preload.

---
 rtl/nanov_spi_ram.sv | 223 ++++++++++++++++++++++
 tb/tb_nanov_spi_ram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_ram.sv
// nanov_spi_ram: SPI RAM responder for the nanoV CPU's serial memory bus.
// It decodes READ (0x03) and WRITE (0x02) commands with a 24-bit address.
// Data streams MSB first, and the address auto-increments modulo 2^ADDR_BITS.
// Backing storage is internal byte memory. A backdoor port preloads it.
//
// Optional feature macro: NANOV_SPI_RAM_FAST_READ_EN
//   When defined, command 0x0B (fast read) is accepted. It inserts 8 dummy
//   bit edges between the address and the data.
//
// Ports:
//   clk            - single clock, rising edge
//   rstn           - synchronous active-low reset
//   spi_select     - chip select, active-low
//   spi_clk_enable - a bit moves only on edges where this is high
//   spi_mosi       - serial data from the CPU
//   spi_miso       - serial data to the CPU (registered)
//   busy           - high whenever the responder is not idle
//   load_en        - backdoor write strobe
//   load_addr      - backdoor byte address
//   load_data      - backdoor byte
module nanov_spi_ram #(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_select,
  input  logic                 spi_clk_enable,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 busy,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
`ifdef NANOV_SPI_RAM_FAST_READ_EN
    ST_DUMMY,
`endif
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_e;

  localparam logic [ADDR_BITS-1:0] AddrOne = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [7:0]           mem_q [2**ADDR_BITS];

  state_e               state_q;
  logic [4:0]           bit_cnt_q;
  logic [6:0]           cmd_q;
  logic [ADDR_BITS-1:0] ptr_q;
  logic [6:0]           wr_sr_q;
  logic [6:0]           rd_sr_q;
  logic                 is_write_q;
`ifdef NANOV_SPI_RAM_FAST_READ_EN
  logic                 fast_q;
`endif
  logic                 miso_q;

  logic                 bit_edge;
  logic [ADDR_BITS-1:0] addr_shift;
  logic [ADDR_BITS-1:0] ptr_inc;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           rd_byte;
  logic [7:0]           wr_byte_d;
  logic                 wr_commit_d;

  assign bit_edge   = !spi_select && spi_clk_enable;
  // The address register shifts through its low bits only.
  // Upper address bits fall off the top, which gives the wrap for free.
  assign addr_shift = {ptr_q[ADDR_BITS-2:0], spi_mosi};
  assign ptr_inc    = ptr_q + AddrOne;
  assign wr_byte_d  = {wr_sr_q, spi_mosi};
  assign wr_commit_d = rstn && bit_edge && (state_q == ST_WRITE) && (bit_cnt_q == 5'd7);

  // Address of the byte that the next read load fetches.
  always_comb begin
    rd_addr = ptr_inc;
    case (state_q)
      ST_ADDR:  rd_addr = addr_shift;
`ifdef NANOV_SPI_RAM_FAST_READ_EN
      ST_DUMMY: rd_addr = ptr_q;
`endif
      default:  rd_addr = ptr_inc;
    endcase
  end

  assign rd_byte = mem_q[rd_addr];

  // The SPI commit is placed after the backdoor load, so on an address
  // collision the SPI commit wins.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
    if (wr_commit_d) mem_q[ptr_q] <= wr_byte_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      ptr_q      <= '0;
      wr_sr_q    <= '0;
      rd_sr_q    <= '0;
      is_write_q <= 1'b0;
`ifdef NANOV_SPI_RAM_FAST_READ_EN
      fast_q     <= 1'b0;
`endif
      miso_q     <= 1'b0;
    end else if (spi_select) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
    end else if (spi_clk_enable) begin
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_CMD;
          cmd_q     <= {6'b0, spi_mosi};
          bit_cnt_q <= 5'd1;
        end
        ST_CMD: begin
          cmd_q     <= {cmd_q[5:0], spi_mosi};
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_q <= '0;
            case ({cmd_q, spi_mosi})
              8'h03: begin
                state_q    <= ST_ADDR;
                is_write_q <= 1'b0;
`ifdef NANOV_SPI_RAM_FAST_READ_EN
                fast_q     <= 1'b0;
`endif
              end
              8'h02: begin
                state_q    <= ST_ADDR;
                is_write_q <= 1'b1;
`ifdef NANOV_SPI_RAM_FAST_READ_EN
                fast_q     <= 1'b0;
`endif
              end
`ifdef NANOV_SPI_RAM_FAST_READ_EN
              8'h0B: begin
                state_q    <= ST_ADDR;
                is_write_q <= 1'b0;
                fast_q     <= 1'b1;
              end
`endif
              default: state_q <= ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          ptr_q     <= addr_shift;
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_q <= '0;
            if (is_write_q) begin
              state_q <= ST_WRITE;
            end
`ifdef NANOV_SPI_RAM_FAST_READ_EN
            else if (fast_q) begin
              state_q <= ST_DUMMY;
              miso_q  <= 1'b0;
            end
`endif
            else begin
              // The first data bit is presented on the same edge that
              // samples address bit 0.
              state_q   <= ST_READ;
              miso_q    <= rd_byte[7];
              rd_sr_q   <= rd_byte[6:0];
              bit_cnt_q <= 5'd1;
            end
          end
        end
`ifdef NANOV_SPI_RAM_FAST_READ_EN
        ST_DUMMY: begin
          miso_q    <= 1'b0;
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            state_q   <= ST_READ;
            miso_q    <= rd_byte[7];
            rd_sr_q   <= rd_byte[6:0];
            bit_cnt_q <= 5'd1;
          end
        end
`endif
        ST_READ: begin
          // bit_cnt_q counts the bits of the current byte already presented.
          if (bit_cnt_q == 5'd8) begin
            ptr_q     <= ptr_inc;
            miso_q    <= rd_byte[7];
            rd_sr_q   <= rd_byte[6:0];
            bit_cnt_q <= 5'd1;
          end else begin
            miso_q    <= rd_sr_q[6];
            rd_sr_q   <= {rd_sr_q[5:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end
        ST_WRITE: begin
          wr_sr_q <= {wr_sr_q[5:0], spi_mosi};
          if (bit_cnt_q == 5'd7) begin
            ptr_q     <= ptr_inc;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end
        ST_IGNORE: miso_q <= 1'b0;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nanov_spi_ram.sv
// Directed bench for nanov_spi_ram.
// It drives SPI transactions bit by bit and compares against hand-computed bytes.
module tb_nanov_spi_ram;

  logic        clk = 1'b0;
  logic        rstn;
  logic        spi_select;
  logic        spi_clk_enable;
  logic        spi_mosi;
  logic        spi_miso;
  logic        busy;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;

  int checks   = 0;
  int failures = 0;

  nanov_spi_ram #(.ADDR_BITS(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .spi_select     (spi_select),
    .spi_clk_enable (spi_clk_enable),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .busy           (busy),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the low n bits of v, MSB first, with one bit edge per bit.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_select     = 1'b0;
      spi_clk_enable = 1'b1;
      spi_mosi       = v[i];
      tick();
    end
    spi_clk_enable = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      b[i] = spi_miso;
      send_bits(32'h0, 1);
    end
  endtask

  task automatic deselect();
    spi_select     = 1'b1;
    spi_clk_enable = 1'b0;
    tick();
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  // Issues a 0x03 read at address a, collects n bytes (n <= 4), then deselects.
  task automatic read_at(input logic [23:0] a, input int n, output logic [31:0] data);
    logic [7:0] b;
    data = '0;
    send_bits({8'h03, a}, 32);
    for (int i = 0; i < n; i++) begin
      read_byte(b);
      data = {data[23:0], b};
    end
    deselect();
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic        held;
    logic        any_one;

    rstn = 1'b0; spi_select = 1'b1; spi_clk_enable = 1'b0; spi_mosi = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    check("rst_miso", {31'b0, spi_miso}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rstn = 1'b1;
    // An edge with spi_select low and spi_clk_enable low is not a bit edge,
    // so the responder must stay idle.
    spi_select = 1'b0; tick();
    check("no_edge_busy", {31'b0, busy}, 32'h0);
    spi_select = 1'b1;

    // Preload, then a 4-byte read. The first data bit appears only after edge 32.
    load(16'h0100, 8'hA5); load(16'h0101, 8'h3C);
    load(16'h0102, 8'h0F); load(16'h0103, 8'hF0);
    send_bits(32'h03000100 >> 1, 31);
    check("lat_pre", {31'b0, spi_miso}, 32'h0);
    check("busy_mid", {31'b0, busy}, 32'h1);
    send_bits(32'h03000100, 1);
    check("lat_first", {31'b0, spi_miso}, 32'h1);
    rd = '0;
    for (int i = 0; i < 4; i++) begin
      read_byte(b);
      rd = {rd[23:0], b};
    end
    check("read4", rd, 32'hA53C0FF0);
    deselect();
    check("desel_busy", {31'b0, busy}, 32'h0);
    check("desel_miso", {31'b0, spi_miso}, 32'h0);

    // busy rises in the cycle after the first bit edge.
    send_bits(32'h0, 1);
    check("busy_rise", {31'b0, busy}, 32'h1);
    deselect();

    // Two-byte write, then read it back.
    send_bits(32'h02000200, 32);
    send_bits(32'h1234, 16);
    deselect();
    read_at(24'h000200, 2, rd);
    check("wr_rd", rd, 32'h1234);

    // A partial third byte is discarded on deselect.
    load(16'h0202, 8'h77);
    send_bits(32'h02000200, 32);
    send_bits(32'hABCD, 16);
    send_bits(32'hE, 4);
    check("part_busy", {31'b0, busy}, 32'h1);
    deselect();
    check("part_busy_fall", {31'b0, busy}, 32'h0);
    read_at(24'h000200, 3, rd);
    check("part_wr", rd, 32'h00ABCD77);

    // Address wrap at the top of storage, and upper address bits ignored.
    load(16'hFFFF, 8'h5A); load(16'h0000, 8'hC3);
    read_at(24'h00FFFF, 2, rd);
    check("wrap", rd, 32'h5AC3);
    read_at(24'hAB0100, 1, rd);
    check("upper_ignored", rd, 32'hA5);

    // Stall mid-byte. The bit must hold, and the stream resumes intact.
    send_bits(32'h03000100, 32);
    b[7] = spi_miso; send_bits(32'h0, 1);
    b[6] = spi_miso; send_bits(32'h0, 1);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      spi_select = 1'b0; spi_clk_enable = 1'b0; tick();
      if (spi_miso !== 1'b1) held = 1'b0;
    end
    check("stall_hold", {31'b0, held}, 32'h1);
    for (int i = 5; i >= 0; i--) begin
      b[i] = spi_miso;
      send_bits(32'h0, 1);
    end
    check("stall_b0", {24'b0, b}, 32'hA5);
    read_byte(b);
    check("stall_b1", {24'b0, b}, 32'h3C);
    deselect();

    // Collision: an SPI commit and a backdoor load to the same address on one edge.
    send_bits(32'h02000300, 32);
    send_bits(32'h11 >> 1, 7);
    load_en = 1'b1; load_addr = 16'h0300; load_data = 8'h99;
    send_bits(32'h1, 1);
    load_en = 1'b0;
    deselect();
    read_at(24'h000300, 1, rd);
    check("collision", rd, 32'h11);

    // An unknown command is ignored. Its data bits must not write memory.
    send_bits(32'hFF000100, 32);
    send_bits(32'h0000, 16);
    deselect();
    read_at(24'h000100, 1, rd);
    check("bad_cmd_mem", rd, 32'hA5);

    // Fast read, command 0x0B.
    send_bits(32'h0B000100, 32);
`ifdef NANOV_SPI_RAM_FAST_READ_EN
    read_byte(b);
    check("fast_dummy", {24'b0, b}, 32'h00);
    read_byte(b);
    check("fast_data", {24'b0, b}, 32'hA5);
    deselect();
`else
    any_one = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (spi_miso !== 1'b0) any_one = 1'b1;
      send_bits(32'h1, 1);
    end
    check("fast_ignored_miso", {31'b0, any_one}, 32'h0);
    deselect();
    read_at(24'h000100, 1, rd);
    check("fast_ignored_mem", rd, 32'hA5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
